// File: rtl/bcd2bin_seq_if.sv
// Handshake and data bundle between a digit-entry front end and the BCD-to-binary converter.
interface bcd2bin_seq_if #(
  parameter int width  = 6,
  parameter int digits = 2
);
  logic                  start;
  logic [4*digits-1:0]   bcd;
  logic [3:0]            bcd_sgn;
  logic                  busy;
  logic                  done;
  logic [width-1:0]      result;
  logic                  err;

  modport master (
    output start, bcd, bcd_sgn,
    input  busy, done, result, err
  );

  modport slave (
    input  start, bcd, bcd_sgn,
    output busy, done, result, err
  );
endinterface

// File: rtl/bcd2bin_seq.sv
// Sequential signed BCD-to-binary converter: reverse double-dabble, one shift per clock,
// with range/illegal-digit checking and a start/busy/done handshake.
module bcd2bin_seq #(
  parameter int width  = 6,
  parameter int digits = 2
) (
  input  logic         clk,
  input  logic         rst,
  bcd2bin_seq_if.slave bus
);
  localparam int ACC_W = 4 * digits;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam int CMP_W = ((ACC_W > width) ? ACC_W : width) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FIX} state_t;

  state_t             state_q;
  logic [ACC_W-1:0]   bcd_q, acc_q;
  logic [ACC_W-1:0]   bcd_d, acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q, bad_q;
  logic               busy_q, done_q, err_q;
  logic [width-1:0]   result_q;

  logic               bad_in;
  logic [CMP_W-1:0]   mag, limit, neg_mag;
  logic               over;

  always_comb begin
    bad_in = 1'b0;
    for (int unsigned i = 0; i < digits; i++) begin
      if (bus.bcd[4*i +: 4] > 4'd9) bad_in = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right, then pull back any nibble that received a carried-in 8.
  always_comb begin
    {bcd_d, acc_d} = {1'b0, bcd_q, acc_q[ACC_W-1:1]};
    for (int unsigned i = 0; i < digits; i++) begin
      if (bcd_d[4*i +: 4] >= 4'd8) bcd_d[4*i +: 4] = bcd_d[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    mag     = CMP_W'(acc_q);
    limit   = neg_q ? (CMP_W'(1) << (width - 1))
                    : (CMP_W'(1) << (width - 1)) - CMP_W'(1);
    neg_mag = -mag;
    over    = (mag > limit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bcd_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      bad_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            bcd_q   <= bus.bcd;
            acc_q   <= '0;
            neg_q   <= (bus.bcd_sgn == 4'hA);
            bad_q   <= bad_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ACC_W - 1)) state_q <= FIX;
        end
        FIX: begin
          if (bad_q || over) begin
            err_q    <= 1'b1;
            result_q <= '0;
          end else begin
            err_q    <= 1'b0;
            result_q <= neg_q ? neg_mag[width-1:0] : mag[width-1:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed, table-driven bench for bcd2bin_seq plus hand-written handshake/reset sequences.
module tb_bcd2bin_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;

  bcd2bin_seq_if #(.width(6), .digits(2)) bus ();

  bcd2bin_seq #(.width(6), .digits(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bcd;
    logic [3:0] sgn;
    logic [5:0] exp_res;
    logic       exp_err;
  } vec_t;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive start for exactly one sampling edge; returns #1 after that edge with start low.
  task automatic launch(input logic [7:0] b, input logic [3:0] s);
    bus.start   = 1'b1;
    bus.bcd     = b;
    bus.bcd_sgn = s;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.bcd     = 8'hFF;
    bus.bcd_sgn = 4'hA;
  endtask

  // Count edges until done is seen (bounded); also counts cycles with busy high.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = bus.busy ? 1 : 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy) busy_cycles++;
    end
  endtask

  vec_t vecs[12];
  int   lat, bc;

  initial begin
    vecs[0]  = '{8'h25, 4'hF, 6'b011001, 1'b0};
    vecs[1]  = '{8'h07, 4'hA, 6'b111001, 1'b0};
    vecs[2]  = '{8'h32, 4'hA, 6'b100000, 1'b0};
    vecs[3]  = '{8'h32, 4'hF, 6'b000000, 1'b1};
    vecs[4]  = '{8'h33, 4'hA, 6'b000000, 1'b1};
    vecs[5]  = '{8'h00, 4'hA, 6'b000000, 1'b0};
    vecs[6]  = '{8'h1B, 4'hF, 6'b000000, 1'b1};
    vecs[7]  = '{8'h99, 4'hF, 6'b000000, 1'b1};
    vecs[8]  = '{8'h31, 4'hF, 6'b011111, 1'b0};
    vecs[9]  = '{8'hA0, 4'hA, 6'b000000, 1'b1};
    vecs[10] = '{8'h01, 4'hA, 6'b111111, 1'b0};
    vecs[11] = '{8'h10, 4'h5, 6'b001010, 1'b0};

    bus.start   = 1'b0;
    bus.bcd     = 8'h00;
    bus.bcd_sgn = 4'h0;
    #12;
    check("reset_result", 32'(bus.result), 32'd0);
    check("reset_err",    32'(bus.err),    32'd0);
    check("reset_done",   32'(bus.done),   32'd0);
    check("reset_busy",   32'(bus.busy),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      launch(vecs[i].bcd, vecs[i].sgn);
      wait_done(lat, bc);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd9);
      check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd9);
      check($sformatf("v%0d_result", i), 32'(bus.result), 32'(vecs[i].exp_res));
      check($sformatf("v%0d_err", i), 32'(bus.err), 32'(vecs[i].exp_err));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
      check($sformatf("v%0d_result_hold", i), 32'(bus.result), 32'(vecs[i].exp_res));
    end

    // start while busy is ignored; start on the done cycle is accepted
    @(negedge clk);
    launch(8'h12, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.bcd     = 8'h31;
    bus.bcd_sgn = 4'hF;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    wait_done(lat, bc);
    check("busy_start_latency", 32'(lat), 32'd6);
    check("busy_start_result",  32'(bus.result), 32'd12);
    check("busy_start_err",     32'(bus.err), 32'd0);
    launch(8'h31, 4'hF);
    wait_done(lat, bc);
    check("b2b_latency", 32'(lat), 32'd9);
    check("b2b_result",  32'(bus.result), 32'd31);
    check("b2b_err",     32'(bus.err), 32'd0);

    // reset mid-conversion aborts without a done pulse
    @(negedge clk);
    launch(8'h25, 4'hF);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_result", 32'(bus.result), 32'd0);
    check("midrst_busy",   32'(bus.busy),   32'd0);
    check("midrst_done",   32'(bus.done),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bc = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) bc++;
    end
    check("midrst_no_activity", 32'(bc), 32'd0);
    @(negedge clk);
    launch(8'h03, 4'hF);
    wait_done(lat, bc);
    check("post_rst_latency", 32'(lat), 32'd9);
    check("post_rst_result",  32'(bus.result), 32'd3);
    check("post_rst_err",     32'(bus.err), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
Sequential BCD-to-binary converter; inverse of the display path's binary-to-BCD conversion. Takes a sign nibble plus `digits` BCD digits, for example from a keypad or digit-entry front end, and produces a signed two's-complement operand of `width` bits for the ALU. It uses reverse double-dabble at one shift per clock, with a start/busy/done handshake and an error flag for illegal digits or out-of-range values.

Parameters:
width, 6, output operand width (signed two's complement)
digits, 2, number of BCD input digits; accumulator internally 4*digits bits

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  request conversion; sampled only in IDLE
bcd  in  4*digits  BCD digits, most significant digit in the top nibble; sampled with start
bcd_sgn  in  4  sign nibble; 4'hA = negative, any other value = positive; sampled with start
busy  out  1  high while state is SHIFT or FIX
done  out  1  one-cycle pulse when result/err are updated
result  out  width  converted signed value; holds until next completion
err  out  1  set with done on illegal digit or range overflow; holds until next completion

Behaviour:
- Reset (async, rst=1): state=IDLE, result=0, err=0, done=0, busy=0, shift counter=0, internal registers cleared. Reset mid-conversion aborts it silently; no done is issued.
- States: IDLE, SHIFT, FIX.
- IDLE, start=1 at edge k:
  - load bcd into the BCD register and clear the binary accumulator;
  - latch neg = (bcd_sgn==4'hA);
  - latch bad = (any digit > 9);
  - counter=0; go to SHIFT.
- IDLE, start=0: stay; done=0.
- SHIFT, one step per edge:
  - shift {bcd_reg, acc} right by 1;
  - then each BCD nibble >= 8 has 3 subtracted;
  - counter++;
  - after 4*digits steps (edges k+1..k+4*digits) go to FIX.
- FIX (edge k+4*digits+1):
  - mag = acc;
  - if neg, limit = 2^(width-1), else limit = 2^(width-1)-1;
  - if bad or mag > limit: err=1, result=0;
  - else err=0, result = neg ? -mag : mag (width-bit truncation of exact value);
  - done=1 for exactly the following cycle; go to IDLE.
- Latency: done high 4*digits+1 edges after the start-sampling edge (9 for digits=2). busy is high for 4*digits+1 cycles.
- start while busy: ignored, with no effect on the in-flight conversion. bcd/bcd_sgn may change freely after the sampling edge.
- start in the cycle done is high (state IDLE): accepted, giving back-to-back throughput of one conversion per 4*digits+1 cycles.
- "-0" gives result=0, err=0. Most negative value (-2^(width-1)) is legal; +2^(width-1) overflows.
- Illegal digit takes priority over the range check; latency is unchanged.
- done is never asserted except via FIX. result/err change only on the FIX edge or reset.

Test Plan:
- Reset, then start with bcd=8'h25, sgn=4'hF → busy high 9 cycles; done pulses on the 9th cycle after the start edge; result=6'b011001, err=0.
- bcd=8'h07, sgn=4'hA → result=6'b111001 (-7), err=0. Then bcd=8'h32, sgn=4'hA → result=6'b100000 (-32), err=0.
- bcd=8'h32, sgn=4'hF → err=1, result=0. Then bcd=8'h33, sgn=4'hA → err=1, result=0. Then bcd=8'h00, sgn=4'hA → result=0, err=0.
- bcd=8'h1B (illegal digit), sgn=4'hF → err=1, result=0, done still at 9 cycles. bcd=8'h99 → err=1.
- Start 8'h12; pulse start with 8'h31 at cycle 4 while busy → it is ignored and result=6'd12. Start 8'h31 on the done cycle → accepted, result=6'd31 nine cycles later.
- Start 8'h25, assert rst at cycle 5 → outputs zero immediately, no done pulse follows. After release, start 8'h03 → result=3 with normal latency.
